// File: rtl/uegk_binarizer.sv
// Serial TU / EGk / UEGk(+sign) bin-string generator for HEVC syntax elements.
// One bin per clock into a right-aligned packed string; overflowing bins are dropped.
module uegk_binarizer #(
  parameter int BIN_WIDTH   = 32,
  parameter int VALUE_WIDTH = 16,
  parameter int CMAX_WIDTH  = 5,
  parameter int K_WIDTH     = 3,
  localparam int LEN_W      = $clog2(BIN_WIDTH + 1),
  localparam int J_W        = $clog2(VALUE_WIDTH + 2**K_WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [VALUE_WIDTH-1:0] value,
  input  logic                   sign,
  input  logic [1:0]             mode,
  input  logic [CMAX_WIDTH-1:0]  cmax,
  input  logic [K_WIDTH-1:0]     k,
  output logic                   busy,
  output logic                   done,
  output logic [BIN_WIDTH-1:0]   bin_string,
  output logic [LEN_W-1:0]       bin_length,
  output logic                   overflow
);

  typedef enum logic [2:0] {IDLE, TU, EG_PFX, EG_SFX, SIGN, DONE} state_t;

  state_t state_q, state_d;

  logic [VALUE_WIDTH-1:0] value_q;
  logic                   sign_q;
  logic [1:0]             mode_q;
  logic [CMAX_WIDTH-1:0]  cmax_q;
  logic [CMAX_WIDTH-1:0]  p_q;
  logic [CMAX_WIDTH-1:0]  tu_cnt;
  logic [VALUE_WIDTH:0]   s_q;
  logic [J_W-1:0]         j_q;

  // Request-time decode, computed from the raw inputs so the first bin
  // lands on the edge right after acceptance.
  logic                   val_lt_cmax;
  logic [CMAX_WIDTH-1:0]  p_in;
  logic [VALUE_WIDTH:0]   s_in;
  state_t                 first_state;

  assign val_lt_cmax = value < VALUE_WIDTH'(cmax);
  assign p_in        = val_lt_cmax ? value[CMAX_WIDTH-1:0] : cmax;
  assign s_in        = (mode == 2'd1) ? {1'b0, value}
                                      : ({1'b0, value} - (VALUE_WIDTH+1)'(cmax));

  always_comb begin
    first_state = EG_PFX;
    if (mode != 2'd1 && cmax != '0) first_state = TU;
    else if (mode == 2'd0)          first_state = DONE;
  end

  // Phase datapath terms.
  logic                 tu_one, tu_last;
  logic [VALUE_WIDTH:0] pw, sfx_shift;
  logic                 eg_ge, sfx_bit;
  logic [J_W-1:0]       jm1;
  state_t               after_eg, after_tu;

  assign tu_one  = tu_cnt < p_q;
  assign tu_last = tu_one ? (({1'b0, tu_cnt} + 1'b1) == {1'b0, p_q} && p_q == cmax_q)
                          : 1'b1;

  // 2^j beyond the s width is larger than any s, so the compare is gated
  // rather than letting the shift wrap to zero.
  assign pw    = (VALUE_WIDTH+1)'(1) << j_q;
  assign eg_ge = (j_q <= J_W'(VALUE_WIDTH)) && (s_q >= pw);

  assign jm1       = j_q - J_W'(1);
  assign sfx_shift = s_q >> jm1;
  assign sfx_bit   = sfx_shift[0];

  assign after_eg = (mode_q == 2'd3 && value_q != '0) ? SIGN : DONE;
  always_comb begin
    after_tu = after_eg;
    if (mode_q == 2'd0)       after_tu = DONE;
    else if (p_q == cmax_q)   after_tu = EG_PFX;
  end

  logic emit, bin;

  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    bin     = 1'b0;
    unique case (state_q)
      IDLE:   if (start) state_d = first_state;
      TU: begin
        emit = 1'b1;
        bin  = tu_one;
        if (tu_last) state_d = after_tu;
      end
      EG_PFX: begin
        emit = 1'b1;
        bin  = eg_ge;
        if (!eg_ge) state_d = (j_q != '0) ? EG_SFX : after_eg;
      end
      EG_SFX: begin
        emit = 1'b1;
        bin  = sfx_bit;
        if (j_q == J_W'(1)) state_d = after_eg;
      end
      SIGN: begin
        emit    = 1'b1;
        bin     = sign_q;
        state_d = DONE;
      end
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      done       <= 1'b0;
      bin_string <= '0;
      bin_length <= '0;
      overflow   <= 1'b0;
      value_q    <= '0;
      sign_q     <= 1'b0;
      mode_q     <= '0;
      cmax_q     <= '0;
      p_q        <= '0;
      tu_cnt     <= '0;
      s_q        <= '0;
      j_q        <= '0;
    end else begin
      done <= (state_q == DONE);

      if (state_q == IDLE && start) begin
        value_q    <= value;
        sign_q     <= sign;
        mode_q     <= mode;
        cmax_q     <= cmax;
        p_q        <= p_in;
        tu_cnt     <= '0;
        s_q        <= s_in;
        j_q        <= J_W'(k);
        bin_string <= '0;
        bin_length <= '0;
        overflow   <= 1'b0;
      end

      // A full string freezes; the walk continues so latency stays N+1.
      if (emit) begin
        if (bin_length == LEN_W'(BIN_WIDTH)) begin
          overflow <= 1'b1;
        end else begin
          bin_string <= {bin_string[BIN_WIDTH-2:0], bin};
          bin_length <= bin_length + LEN_W'(1);
        end
      end

      unique case (state_q)
        TU:     if (tu_one) tu_cnt <= tu_cnt + CMAX_WIDTH'(1);
        EG_PFX: if (eg_ge) begin
                  s_q <= s_q - pw;
                  j_q <= j_q + J_W'(1);
                end
        EG_SFX: j_q <= jm1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uegk_binarizer.sv
// Directed bench for uegk_binarizer (BIN_WIDTH=16) with hand-computed bin strings.
module tb_uegk_binarizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] value;
  logic        sign;
  logic [1:0]  mode;
  logic [4:0]  cmax;
  logic [2:0]  k;
  logic        busy;
  logic        done;
  logic [15:0] bin_string;
  logic [4:0]  bin_length;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  uegk_binarizer #(
    .BIN_WIDTH(16), .VALUE_WIDTH(16), .CMAX_WIDTH(5), .K_WIDTH(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .value(value), .sign(sign),
    .mode(mode), .cmax(cmax), .k(k), .busy(busy), .done(done),
    .bin_string(bin_string), .bin_length(bin_length), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait (bounded) for done, check latency and result.
  // poke > 0 pulses a conflicting start that many cycles after acceptance.
  task automatic run_req(input string tag, input logic [1:0] m, input logic [4:0] c,
                         input logic [2:0] kk, input logic [15:0] v, input logic sg,
                         input int poke, input int exp_lat, input logic [15:0] exp_str,
                         input int exp_len, input logic exp_ovf);
    int cyc;
    @(negedge clk);
    start = 1'b1; mode = m; cmax = c; k = kk; value = v; sign = sg;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "/busy_on"}, busy, 1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (cyc == poke) begin
        start = 1'b1; mode = 2'd0; cmax = 5'd2; value = 16'd1;
      end
    end
    start = 1'b0;
    chk({tag, "/done"}, done, 1);
    chk({tag, "/latency"}, cyc, exp_lat);
    chk({tag, "/string"}, bin_string, exp_str);
    chk({tag, "/length"}, bin_length, exp_len);
    chk({tag, "/overflow"}, overflow, exp_ovf);
    chk({tag, "/busy_off"}, busy, 0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; value = '0; sign = 1'b0; mode = '0; cmax = '0; k = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset/busy", busy, 0);
    chk("reset/done", done, 0);
    chk("reset/string", bin_string, 0);
    chk("reset/length", bin_length, 0);
    chk("reset/overflow", overflow, 0);
    rst = 1'b0;

    // UEGk small value: 1110
    run_req("uegk_v3", 2'd2, 5'd5, 3'd0, 16'd3, 1'b0, 0, 5, 16'h000E, 4, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold/done", done, 0);
    chk("hold/string", bin_string, 16'h000E);
    chk("hold/length", bin_length, 4);

    // UEGk with EG0 suffix: 11111 110 00
    run_req("uegk_v8", 2'd2, 5'd5, 3'd0, 16'd8, 1'b0, 0, 11, 16'h03F8, 10, 1'b0);
    // Back-to-back start in the done cycle: 10
    run_req("uegk_v1", 2'd2, 5'd5, 3'd0, 16'd1, 1'b0, 0, 3, 16'h0002, 2, 1'b0);
    // Sign bin appended
    run_req("sign_v8", 2'd3, 5'd5, 3'd0, 16'd8, 1'b1, 0, 12, 16'h07F1, 11, 1'b0);
    // value 0: TU terminator only, no sign bin
    run_req("sign_v0", 2'd3, 5'd5, 3'd0, 16'd0, 1'b1, 0, 2, 16'h0000, 1, 1'b0);
    // EG1 of 5: 10 11
    run_req("eg1_v5", 2'd1, 5'd5, 3'd1, 16'd5, 1'b0, 0, 5, 16'h000B, 4, 1'b0);
    // TU clipped at cmax: no terminator
    run_req("tu_v9", 2'd0, 5'd5, 3'd0, 16'd9, 1'b0, 0, 6, 16'h001F, 5, 1'b0);
    // Empty binarization
    run_req("tu_c0", 2'd0, 5'd0, 3'd0, 16'd7, 1'b0, 0, 1, 16'h0000, 0, 1'b0);
    // EG0 of 0xFFFF: 16 ones, 0, 16 zeros -> 33 bins, only first 16 kept
    run_req("ovf", 2'd1, 5'd0, 3'd0, 16'hFFFF, 1'b0, 0, 34, 16'hFFFF, 16, 1'b1);
    // Overflow clears on the next request; conflicting start mid-flight is ignored
    run_req("busy_poke", 2'd2, 5'd5, 3'd0, 16'd8, 1'b0, 3, 11, 16'h03F8, 10, 1'b0);

    // Reset during a request
    @(negedge clk);
    start = 1'b1; mode = 2'd2; cmax = 5'd5; k = 3'd0; value = 16'd8; sign = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort/len_before", bin_length, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort/busy", busy, 0);
    chk("abort/done", done, 0);
    chk("abort/string", bin_string, 0);
    chk("abort/length", bin_length, 0);
    chk("abort/overflow", overflow, 0);
    rst = 1'b0;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1;
    end
    chk("abort/no_done", seen, 0);

    // Following request: 11111 110 00 + sign 0
    run_req("after_rst", 2'd3, 5'd5, 3'd0, 16'd8, 1'b0, 0, 12, 16'h07F0, 11, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
